maze_path_replayer: RTL and testbench

Downstream of the maze solver; consumes the solver's per-step move stream.
- During solving: keeps the current path as a LIFO. The solver pushes a move on advance and pops on backtrack.
- After the solver reports done: replays the surviving path in start-to-goal order to a consumer (display/robot driver) under a valid/ready handshake.
- Replay can be repeated on each run request until the next solve starts.

---
 rtl/maze_path_replayer.sv | 195 +++++++++++++++++++
 tb/tb_maze_path_replayer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_path_replayer.sv
`default_nettype none
// ============================================================================
// Module   : maze_path_replayer
// Purpose  : Records the maze solver's move path as a LIFO, then replays it
//            start-to-goal to a consumer over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module maze_path_replayer #(
    parameter int DEPTH  = 256,
    parameter int MOVE_W = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              push,
    input  logic              pop,
    input  logic [MOVE_W-1:0] move_in,
    input  logic              done_in,
    input  logic              fail_in,
    input  logic              run,
    input  logic              move_ready,
    output logic [MOVE_W-1:0] move_out,
    output logic              move_valid,
    output logic              replay_busy,
    output logic              replay_done,
    output logic              path_fail,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RECORD   = 3'd1,
        S_READY    = 3'd2,
        S_REPLAY   = 3'd3,
        S_FINISHED = 3'd4
    } state_t;

    logic [MOVE_W-1:0] r_mem [DEPTH];

    state_t            r_state,      w_state_nxt;
    logic [CNT_W-1:0]  r_sp,         w_sp_nxt;
    logic [CNT_W-1:0]  r_rd_ptr,     w_rd_ptr_nxt;
    logic [MOVE_W-1:0] r_move_out,   w_move_out_nxt;
    logic              r_move_valid, w_move_valid_nxt;
    logic              r_replay_done, w_replay_done_nxt;
    logic              r_path_fail,  w_path_fail_nxt;
    logic              r_overflow,   w_overflow_nxt;
    logic              r_underflow,  w_underflow_nxt;

    logic                w_we;
    logic [c_ADDR_W-1:0] w_waddr;
    logic [CNT_W-1:0]    w_sp_m1;
    logic [CNT_W-1:0]    w_rd_inc;
    logic                w_full;
    logic                w_empty;

    assign w_full   = (r_sp == CNT_W'(DEPTH));
    assign w_empty  = (r_sp == '0);
    assign w_sp_m1  = r_sp - CNT_W'(1);
    assign w_rd_inc = r_rd_ptr + CNT_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_sp_nxt          = r_sp;
        w_rd_ptr_nxt      = r_rd_ptr;
        w_move_out_nxt    = r_move_out;
        w_move_valid_nxt  = r_move_valid;
        w_replay_done_nxt = 1'b0;
        w_path_fail_nxt   = r_path_fail;
        w_overflow_nxt    = r_overflow;
        w_underflow_nxt   = r_underflow;
        w_we              = 1'b0;
        w_waddr           = r_sp[c_ADDR_W-1:0];

        if (start) begin
            w_state_nxt      = S_RECORD;
            w_sp_nxt         = '0;
            w_path_fail_nxt  = 1'b0;
            w_overflow_nxt   = 1'b0;
            w_underflow_nxt  = 1'b0;
            w_move_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_RECORD: begin
                    // A push+pop on an empty stack degenerates to a plain push.
                    if (push && (!pop || w_empty)) begin
                        if (w_full) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_we     = 1'b1;
                            w_sp_nxt = r_sp + CNT_W'(1);
                        end
                    end else if (push && pop) begin
                        w_we    = 1'b1;
                        w_waddr = w_sp_m1[c_ADDR_W-1:0];
                    end else if (pop) begin
                        if (w_empty) begin
                            w_underflow_nxt = 1'b1;
                        end else begin
                            w_sp_nxt = w_sp_m1;
                        end
                    end

                    if (fail_in) begin
                        w_state_nxt     = S_READY;
                        w_sp_nxt        = '0;
                        w_path_fail_nxt = 1'b1;
                    end else if (done_in) begin
                        w_state_nxt = S_READY;
                    end
                end

                S_READY, S_FINISHED: begin
                    if (run) begin
                        w_rd_ptr_nxt = '0;
                        if (w_empty) begin
                            w_state_nxt       = S_FINISHED;
                            w_replay_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt      = S_REPLAY;
                            w_move_valid_nxt = 1'b1;
                            w_move_out_nxt   = r_mem[0];
                        end
                    end
                end

                S_REPLAY: begin
                    if (r_move_valid && move_ready) begin
                        if (r_rd_ptr == w_sp_m1) begin
                            w_move_valid_nxt  = 1'b0;
                            w_state_nxt       = S_FINISHED;
                            w_replay_done_nxt = 1'b1;
                        end else begin
                            w_rd_ptr_nxt   = w_rd_inc;
                            w_move_out_nxt = r_mem[w_rd_inc[c_ADDR_W-1:0]];
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sp          <= '0;
            r_rd_ptr      <= '0;
            r_move_out    <= '0;
            r_move_valid  <= 1'b0;
            r_replay_done <= 1'b0;
            r_path_fail   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sp          <= w_sp_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_move_out    <= w_move_out_nxt;
            r_move_valid  <= w_move_valid_nxt;
            r_replay_done <= w_replay_done_nxt;
            r_path_fail   <= w_path_fail_nxt;
            r_overflow    <= w_overflow_nxt;
            r_underflow   <= w_underflow_nxt;
        end
    end

    // Path storage is never cleared; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[w_waddr] <= move_in;
        end
    end

    assign move_out    = r_move_out;
    assign move_valid  = r_move_valid;
    assign replay_busy = (r_state == S_REPLAY);
    assign replay_done = r_replay_done;
    assign path_fail   = r_path_fail;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_sp;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_maze_path_replayer.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_path_replayer
// Purpose  : Self-checking bench; a queue-based path model predicts every
//            status flag and the replayed move sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maze_path_replayer;

    localparam int DEPTH  = 256;
    localparam int MOVE_W = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0, push = 1'b0, pop = 1'b0;
    logic              done_in = 1'b0, fail_in = 1'b0, run = 1'b0;
    logic              move_ready = 1'b0;
    logic [MOVE_W-1:0] move_in = '0;
    logic [MOVE_W-1:0] move_out;
    logic              move_valid, replay_busy, replay_done, path_fail;
    logic              full, empty, overflow, underflow;
    logic [CNT_W-1:0]  count;

    maze_path_replayer #(.DEPTH(DEPTH), .MOVE_W(MOVE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop),
        .move_in(move_in), .done_in(done_in), .fail_in(fail_in), .run(run),
        .move_ready(move_ready), .move_out(move_out), .move_valid(move_valid),
        .replay_busy(replay_busy), .replay_done(replay_done),
        .path_fail(path_fail), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model: the surviving path, oldest move first.
    int q[$];
    bit m_rec, m_pf, m_ovf, m_unf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_status(input string tag);
        check({tag, ".count"}, 32'(count), q.size());
        check({tag, ".full"}, 32'(full), (q.size() == DEPTH) ? 1 : 0);
        check({tag, ".empty"}, 32'(empty), (q.size() == 0) ? 1 : 0);
        check({tag, ".overflow"}, 32'(overflow), m_ovf);
        check({tag, ".underflow"}, 32'(underflow), m_unf);
        check({tag, ".path_fail"}, 32'(path_fail), m_pf);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        m_rec = 0; m_pf = 0; m_ovf = 0; m_unf = 0;
        chk_status("reset");
        check("reset.move_valid", 32'(move_valid), 0);
        check("reset.replay_busy", 32'(replay_busy), 0);
        check("reset.replay_done", 32'(replay_done), 0);
        check("reset.move_out", 32'(move_out), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        q.delete();
        m_rec = 1; m_pf = 0; m_ovf = 0; m_unf = 0;
        chk_status("start");
        check("start.move_valid", 32'(move_valid), 0);
    endtask

    task automatic rec(input bit pu, input bit po, input int mv, input bit dn, input bit fl);
        push = pu; pop = po; move_in = MOVE_W'(mv); done_in = dn; fail_in = fl;
        tick();
        push = 0; pop = 0; done_in = 0; fail_in = 0;
        if (m_rec) begin
            if (pu && po && q.size() > 0) q[q.size()-1] = mv;
            else if (pu) begin
                if (q.size() == DEPTH) m_ovf = 1;
                else q.push_back(mv);
            end else if (po) begin
                if (q.size() == 0) m_unf = 1;
                else void'(q.pop_back());
            end
            if (fl) begin
                q.delete();
                m_pf = 1;
                m_rec = 0;
            end else if (dn) begin
                m_rec = 0;
            end
        end
        chk_status("rec");
    endtask

    // Pulses run, then follows the handshake; ready drops for stall_len
    // cycles when move index stall_at is presented, and randomly otherwise.
    task automatic replay(input int stall_pct, input int stall_at, input int stall_len);
        int idx = 0;
        int n = q.size();
        int stalls = stall_len;
        bit rdy;
        run = 1'b1;
        tick();
        run = 1'b0;
        if (n == 0) begin
            check("empty_replay.move_valid", 32'(move_valid), 0);
            check("empty_replay.replay_done", 32'(replay_done), 1);
            tick();
            check("empty_replay.done_after", 32'(replay_done), 0);
            check("empty_replay.valid_after", 32'(move_valid), 0);
            return;
        end
        for (int cyc = 0; cyc < 4 * n + 40; cyc++) begin
            check("replay.move_valid", 32'(move_valid), 1);
            check("replay.move_out", 32'(move_out), q[idx]);
            check("replay.busy", 32'(replay_busy), 1);
            check("replay.done_early", 32'(replay_done), 0);
            check("replay.count", 32'(count), n);
            if (idx == stall_at && stalls > 0) begin
                rdy = 0;
                stalls--;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            move_ready = rdy;
            tick();
            if (rdy) idx++;
            if (idx == n) break;
        end
        move_ready = 1'b0;
        check("replay.all_moves_taken", idx, n);
        check("replay.end_valid", 32'(move_valid), 0);
        check("replay.end_done", 32'(replay_done), 1);
        check("replay.end_busy", 32'(replay_busy), 0);
        tick();
        check("replay.done_pulse_len", 32'(replay_done), 0);
        check("replay.count_after", 32'(count), n);
    endtask

    initial begin
        // Reset, and run while idle is ignored.
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        check("idle_run.move_valid", 32'(move_valid), 0);
        check("idle_run.replay_done", 32'(replay_done), 0);
        check("idle_run.busy", 32'(replay_busy), 0);

        // Basic record and full-speed replay.
        do_start();
        rec(1, 0, 1, 0, 0);
        rec(1, 0, 2, 0, 0);
        rec(1, 0, 3, 0, 0);
        rec(1, 0, 0, 0, 0);
        rec(0, 0, 0, 1, 0);
        replay(0, -1, 0);

        // Backtrack and replace-top.
        do_start();
        rec(1, 0, 1, 0, 0);
        rec(1, 0, 2, 0, 0);
        rec(1, 0, 3, 0, 0);
        rec(0, 1, 0, 0, 0);
        rec(1, 1, 0, 0, 0);
        rec(0, 0, 0, 1, 0);
        check("replace.count", 32'(count), 2);
        replay(0, -1, 0);

        // Fill, overflow, drain past empty, then replay an empty path.
        do_start();
        for (int i = 0; i < DEPTH; i++) rec(1, 0, $urandom_range(3), 0, 0);
        rec(1, 0, 1, 0, 0);
        check("overflow.full", 32'(full), 1);
        for (int i = 0; i <= DEPTH; i++) rec(0, 1, 0, 0, 0);
        check("underflow.flag", 32'(underflow), 1);
        rec(0, 0, 0, 1, 0);
        replay(0, -1, 0);

        // fail_in beats done_in; later activity in READY is ignored.
        do_start();
        rec(1, 0, 1, 0, 0);
        rec(1, 0, 2, 0, 0);
        rec(1, 0, 3, 0, 0);
        rec(0, 0, 0, 1, 1);
        rec(1, 0, 2, 0, 0);
        check("fail.path_fail", 32'(path_fail), 1);
        replay(0, -1, 0);

        // Consumer stall on the second move.
        do_start();
        rec(1, 0, 2, 0, 0);
        rec(1, 0, 3, 0, 0);
        rec(1, 0, 1, 0, 0);
        rec(0, 0, 0, 1, 0);
        replay(0, 1, 2);

        // Reset in the middle of a replay, then a fresh path replayed twice.
        do_start();
        for (int i = 0; i < 5; i++) rec(1, 0, $urandom_range(3), 0, 0);
        rec(0, 0, 0, 1, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        check("midreplay.valid", 32'(move_valid), 1);
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) rec(1, 0, $urandom_range(3), 0, 0);
        rec(1, 0, $urandom_range(3), 1, 0);
        replay(25, -1, 0);
        replay(25, -1, 0);

        // Randomized solver walks.
        for (int t = 0; t < 4; t++) begin
            do_start();
            for (int s = 0; s < 60; s++) begin
                int r = $urandom_range(99);
                rec(r < 60 || (r >= 85), r >= 60, $urandom_range(3), 0, 0);
            end
            rec($urandom_range(1), 0, $urandom_range(3), 1, 0);
            replay(30, -1, 0);
            replay(30, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
